// File: rtl/ext_pll_ready_monitor.sv
// Qualifies an asynchronous external PLL lock into a registered ready flag. The PLL is
// reset on lock timeout or after a lock loss. The loss counter exists only when EXT_PLL_LOSS_COUNTER_EN is defined.
module ext_pll_ready_monitor #(
    parameter int unsigned PLL_RST_CYCLES      = 1000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned STABLE_CYCLES       = 100000,
    parameter int unsigned HOLDOFF_CYCLES      = 10000
) (
    input  logic        clk_ik,
    input  logic        rst_ir,
    input  logic        pll_lock_ia,
    input  logic        clear_count_i,
    output logic        pll_rst_o,
    output logic        ext_pll_ready_o,
    output logic [2:0]  state_o,
    output logic [15:0] loss_count_o
);
    localparam int unsigned MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD     = (STABLE_CYCLES > HOLDOFF_CYCLES) ? STABLE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    // Every phase leaves on the last cycle of its count.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_READY     = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_meta_q, lock_sync_q;
    logic             ready_q, pll_rst_q;

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_ia;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_sync_q)                state_d = S_STABLE;
                else if (cnt_q == TIMEOUT_LAST) state_d = S_PLLRST;
            end
            S_STABLE: begin
                if (!lock_sync_q)              state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_READY;
            end
            S_READY: begin
                if (!lock_sync_q) state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLDOFF_LAST) state_d = S_PLLRST;
            end
            default: state_d = S_PLLRST;
        endcase
    end

    // Outputs are registered from the next state, so they always match state_q exactly.
    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            pll_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == S_READY);
            pll_rst_q <= (state_d == S_PLLRST);
            if (state_d != state_q)     cnt_q <= '0;
            else if (state_q != S_READY) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pll_rst_o       = pll_rst_q;
    assign ext_pll_ready_o = ready_q;
    assign state_o         = state_q;

`ifdef EXT_PLL_LOSS_COUNTER_EN
    logic [15:0] loss_q;
    logic        loss_inc;

    assign loss_inc = (state_q == S_READY) && (state_d == S_HOLDOFF);

    // A clear wins over a coincident loss; the count saturates rather than wrapping.
    always_ff @(posedge clk_ik) begin
        if (rst_ir || clear_count_i) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != 16'hFFFF)) begin
            loss_q <= loss_q + 16'd1;
        end
    end

    assign loss_count_o = loss_q;
`else
    logic unused_clear;
    assign unused_clear = clear_count_i;
    assign loss_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ext_pll_ready_monitor.sv
// Bench for ext_pll_ready_monitor: a table of directed sequences, loss-counter corner cases,
// then random lock activity compared against a timestamp-based model of the lock qualification rules.
module tb_ext_pll_ready_monitor;
    localparam int unsigned P_RST = 4;
    localparam int unsigned P_TO  = 50;
    localparam int unsigned P_ST  = 16;
    localparam int unsigned P_HO  = 8;
`ifdef EXT_PLL_LOSS_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [15:0] L1  = CNT_EN ? 16'd1 : 16'd0;
    localparam logic [15:0] SAT = CNT_EN ? 16'hFFFF : 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lock = 1'b0;
    logic        clr = 1'b0;
    logic        pll_rst, ready;
    logic [2:0]  state;
    logic [15:0] loss;

    always #5 clk = ~clk;

    ext_pll_ready_monitor #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .STABLE_CYCLES(P_ST),
        .HOLDOFF_CYCLES(P_HO)
    ) dut (
        .clk_ik(clk),
        .rst_ir(rst),
        .pll_lock_ia(lock),
        .clear_count_i(clr),
        .pll_rst_o(pll_rst),
        .ext_pll_ready_o(ready),
        .state_o(state),
        .loss_count_o(loss)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: each phase remembers the edge it was entered on; lock seen by the
    // qualifier is the raw input from two edges earlier (zero right after reset).
    int unsigned cyc = 0;
    int unsigned m_entered = 0;
    int          m_phase = 0;
    bit          m_hist[$];
    bit          m_seen;
    logic [15:0] m_loss = 16'h0;

    task automatic go(input int p);
        m_phase   = p;
        m_entered = cyc;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            go(0);
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
            m_loss = 16'h0;
        end else begin
            m_seen = m_hist.pop_front();
            m_hist.push_back(lock);
            case (m_phase)
                0: if (cyc - m_entered >= P_RST) go(1);
                1: if (m_seen) go(2); else if (cyc - m_entered >= P_TO) go(0);
                2: if (!m_seen) go(1); else if (cyc - m_entered >= P_ST) go(3);
                3: if (!m_seen) begin
                       go(4);
                       if (CNT_EN && m_loss != 16'hFFFF) m_loss = m_loss + 16'd1;
                   end
                4: if (cyc - m_entered >= P_HO) go(0);
                default: go(0);
            endcase
            if (CNT_EN && clr) m_loss = 16'h0;
        end
    end

    typedef struct {
        logic        rst, lk, cl;
        int          n;
        logic [2:0]  st;
        logic        rdy, prst;
        logic [15:0] ls;
    } seg_t;

    seg_t tbl[$];

    task automatic add(input logic r, input logic l, input logic c, input int n,
                       input logic [2:0] st, input logic rdy, input logic prst, input logic [15:0] ls);
        seg_t s;
        s.rst = r; s.lk = l; s.cl = c; s.n = n;
        s.st = st; s.rdy = rdy; s.prst = prst; s.ls = ls;
        tbl.push_back(s);
    endtask

    task automatic drive(input logic r, input logic l, input logic c, input int n);
        rst = r; lock = l; clr = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic rdy,
                              input logic prst, input logic [15:0] ls);
        check({tag, "_state"}, 16'(state), 16'(st));
        check({tag, "_ready"}, 16'(ready), 16'(rdy));
        check({tag, "_pllrst"}, 16'(pll_rst), 16'(prst));
        check({tag, "_loss"}, loss, ls);
    endtask

    bit run_val;
    int run_left;

    initial begin
        // Reset, lock held high from release: 4-cycle PLL reset, qualify, ready.
        add(1, 1, 0, 2,  3'd0, 0, 1, 16'd0);
        add(0, 1, 0, 3,  3'd0, 0, 1, 16'd0);
        add(0, 1, 0, 1,  3'd1, 0, 0, 16'd0);
        add(0, 1, 0, 1,  3'd2, 0, 0, 16'd0);
        add(0, 1, 0, 15, 3'd2, 0, 0, 16'd0);
        add(0, 1, 0, 1,  3'd3, 1, 0, 16'd0);
        add(0, 1, 0, 5,  3'd3, 1, 0, 16'd0);
        // Lock loss in READY: ready drops on the third edge, then holdoff ignores lock.
        add(0, 0, 0, 2,  3'd3, 1, 0, 16'd0);
        add(0, 0, 0, 1,  3'd4, 0, 0, L1);
        add(0, 1, 0, 3,  3'd4, 0, 0, L1);
        add(0, 0, 0, 4,  3'd4, 0, 0, L1);
        add(0, 0, 0, 1,  3'd0, 0, 1, L1);
        add(0, 0, 0, 3,  3'd0, 0, 1, L1);
        add(0, 0, 0, 1,  3'd1, 0, 0, L1);
        // No lock: timeout back to a fresh PLL reset pulse.
        add(0, 0, 0, 49, 3'd1, 0, 0, L1);
        add(0, 0, 0, 1,  3'd0, 0, 1, L1);
        add(0, 0, 0, 3,  3'd0, 0, 1, L1);
        add(0, 0, 0, 1,  3'd1, 0, 0, L1);
        // One-cycle glitch seen at STABLE count 10, then a full stable period.
        add(0, 1, 0, 2,  3'd1, 0, 0, L1);
        add(0, 1, 0, 1,  3'd2, 0, 0, L1);
        add(0, 1, 0, 8,  3'd2, 0, 0, L1);
        add(0, 0, 0, 1,  3'd2, 0, 0, L1);
        add(0, 1, 0, 1,  3'd2, 0, 0, L1);
        add(0, 1, 0, 1,  3'd1, 0, 0, L1);
        add(0, 1, 0, 1,  3'd2, 0, 0, L1);
        add(0, 1, 0, 15, 3'd2, 0, 0, L1);
        add(0, 1, 0, 1,  3'd3, 1, 0, L1);
        add(0, 1, 1, 1,  3'd3, 1, 0, 16'd0);
        // One-cycle reset while READY, then the whole sequence again.
        add(1, 1, 0, 1,  3'd0, 0, 1, 16'd0);
        add(0, 1, 0, 3,  3'd0, 0, 1, 16'd0);
        add(0, 1, 0, 1,  3'd1, 0, 0, 16'd0);
        add(0, 1, 0, 1,  3'd2, 0, 0, 16'd0);
        add(0, 1, 0, 15, 3'd2, 0, 0, 16'd0);
        add(0, 1, 0, 1,  3'd3, 1, 0, 16'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].lk, tbl[i].cl, tbl[i].n);
            check_outs($sformatf("seg%0d", i), tbl[i].st, tbl[i].rdy, tbl[i].prst, tbl[i].ls);
        end

        // Saturation at 16'hFFFF, then a clear coincident with a loss.
`ifdef EXT_PLL_LOSS_COUNTER_EN
        force dut.loss_q = 16'hFFFF;
        #1;
        release dut.loss_q;
        m_loss = 16'hFFFF;
`endif
        drive(0, 0, 0, 2);
        check_outs("sat_pre", 3'd3, 1'b1, 1'b0, SAT);
        drive(0, 0, 0, 1);
        check_outs("sat_loss", 3'd4, 1'b0, 1'b0, SAT);
        drive(0, 1, 0, 40);
        check_outs("sat_relock", 3'd3, 1'b1, 1'b0, SAT);
        drive(0, 0, 0, 2);
        drive(0, 0, 1, 1);
        check_outs("clr_vs_loss", 3'd4, 1'b0, 1'b0, 16'd0);
        drive(0, 0, 0, 1);

        // Random lock runs with occasional resets and clears.
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                run_val  = ($urandom_range(0, 9) < 7);
                run_left = $urandom_range(1, 60);
            end
            run_left--;
            drive(($urandom_range(0, 299) == 0), run_val, ($urandom_range(0, 49) == 0), 1);
            check("rnd_state", 16'(state), 16'(m_phase));
            check("rnd_ready", 16'(ready), 16'(m_phase == 3));
            check("rnd_pllrst", 16'(pll_rst), 16'(m_phase == 0));
            check("rnd_loss", loss, m_loss);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ext_pll_ready_monitor.md
EXT_PLL_READY_MONITOR -- requirements
Module: ext_pll_ready_monitor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 1000, PLL reset pulse length in clk_ik cycles (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000, maximum wait for lock after PLL reset release.
REQ-003 SHALL have parameter STABLE_CYCLES, default 100000, continuous lock time required before ready (1 ms at 100 MHz).
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 10000, quiet time after a lock loss before the PLL is reset again.
REQ-005 SHALL have port clk_ik  input  1  100 MHz free-running system clock, the only clock.
REQ-006 SHALL have port rst_ir  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pll_lock_ia  input  1  external 120 MHz PLL lock, asynchronous.
REQ-008 SHALL have port clear_count_i  input  1  synchronous clear of loss_count_o.
REQ-009 SHALL have port pll_rst_o  output  1  reset request to the external PLL, active-high.
REQ-010 SHALL have port ext_pll_ready_o  output  1  qualified PLL ready, consumed as ext_pll_ready by the system clock/reset block.
REQ-011 SHALL have port state_o  output  3  current FSM state code.
REQ-012 SHALL have port loss_count_o  output  16  count of lock losses seen in READY.

Function
REQ-013 SHALL synchronise pll_lock_ia through a 2-flop synchroniser; "lock" below means the synchroniser output (2-cycle latency).
REQ-014 SHALL implement FSM states: PLLRST=0, WAIT_LOCK=1, STABLE=2, READY=3, HOLDOFF=4; codes 5-7 unreachable and SHALL return to PLLRST.
REQ-015 PLLRST: pll_rst_o=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
REQ-016 WAIT_LOCK: lock=1 -> STABLE; else after LOCK_TIMEOUT_CYCLES cycles without lock -> PLLRST.
REQ-017 STABLE: lock=0 -> WAIT_LOCK with timeout counter restarted; lock held for STABLE_CYCLES consecutive cycles -> READY.
REQ-018 READY: lock=0 -> HOLDOFF; loss_count_o increments in the same transition.
REQ-019 HOLDOFF: stays HOLDOFF_CYCLES cycles regardless of lock, then PLLRST.
REQ-020 ext_pll_ready_o and pll_rst_o SHALL be registered and equal (state==READY) and (state==PLLRST) respectively, with no combinational path from inputs.
REQ-021 ext_pll_ready_o SHALL deassert no later than 3 clk_ik cycles after pll_lock_ia falls (2 sync + 1 register).
REQ-022 A single shared cycle counter of width clog2 of the largest parameter SHALL be used, cleared on every state change.
REQ-023 loss_count_o SHALL saturate at 16'hFFFF, never wrap.
REQ-024 clear_count_i SHALL zero loss_count_o next cycle and take priority over a simultaneous increment.

Reset
REQ-025 rst_ir=1 SHALL force state PLLRST, counters 0, synchroniser flops 0, loss_count_o 0, ext_pll_ready_o 0, pll_rst_o 1 on the next edge.
REQ-026 rst_ir asserted in any state, including mid-count, SHALL abort the sequence; on release the full PLLRST period SHALL be re-run.

Configuration
REQ-027 Macro EXT_PLL_LOSS_COUNTER_EN: defined -> loss counter and clear_count_i function per REQ-018/023/024.
REQ-028 Macro undefined -> no counter logic; loss_count_o tied to 16'h0000, clear_count_i ignored; FSM behaviour unchanged.

Verification (params PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, STABLE_CYCLES=16, HOLDOFF_CYCLES=8)
REQ-029 Reset release, lock held 1 -> pll_rst_o high exactly 4 cycles, ext_pll_ready_o rises 16 cycles after the synchronised lock plus 1 register cycle, state_o=3.
REQ-030 Lock never asserts -> pll_rst_o pulses 4 cycles every 54 cycles, ext_pll_ready_o stays 0.
REQ-031 Lock glitch low 1 cycle at STABLE count 10 -> state_o returns to 1 then 2, ready delayed a full 16 cycles after re-lock, loss_count_o unchanged.
REQ-032 Lock drop in READY -> ready 0 within 3 cycles, loss_count_o +1, HOLDOFF 8 cycles, then 4-cycle pll_rst_o pulse.
REQ-033 Preload loss_count_o to 16'hFFFF, cause another loss -> stays 16'hFFFF; clear_count_i coincident with a loss -> 16'h0000.
REQ-034 rst_ir asserted 1 cycle while in READY -> ready 0 and pll_rst_o 1 next cycle, full sequence repeats; with macro undefined loss_count_o reads 0 throughout.
